counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
Controller that configures and sequences the team's 8-bit free-running counter datapath. It accepts a run configuration over a valid/ready handshake: start, end, step, prescale and reload mode. It then drives the counter value through the programmed sequence, with pause, abort and completion signalling. It sits between the top-level control logic and the counter_out observation bus.

Parameters:
WIDTH, 8, counter/config value width
PRE_W, 8, prescale field width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (rst==0 at a rising clk edge resets the block)
cfg_valid  in  1  requester presents a configuration
cfg_ready  out  1  block accepts a configuration this cycle
cfg_start  in  WIDTH  first counter value
cfg_end  in  WIDTH  terminal counter value
cfg_step  in  WIDTH  increment per tick; 0 treated as 1
cfg_prescale  in  PRE_W  tick every prescale+1 cycles
cfg_reload  in  1  1 = auto-restart at terminal, 0 = one-shot
pause  in  1  freeze sequencing while high
abort  in  1  terminate current run
counter_out  out  WIDTH  current counter value (registered)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at one-shot completion
wrap  out  1  one-cycle pulse at each reload-mode restart
aborted  out  1  one-cycle pulse when abort is taken

Behaviour:
- Reset (rst==0 at edge): state=IDLE, counter_out=0, pre_cnt=0, done/wrap/aborted=0, config registers=0. cfg_ready=0 while rst==0.
- cfg_ready = (state==IDLE) && rst.
- Accept: cfg_valid && cfg_ready at edge E0 latches all cfg_* fields, sets counter_out=cfg_start and pre_cnt=0, and moves to RUN. cfg_* are ignored outside IDLE.
- Prescaler: in RUN, a tick occurs at the edge where pre_cnt==prescale. On a tick pre_cnt returns to 0; otherwise it increments. The first tick is at edge E0+prescale+1.
- Terminal condition on a tick: counter_out >= end (unsigned).
- Non-terminal tick: sum = counter_out + step, computed WIDTH+1 bits wide. counter_out = (sum > end) ? end : sum. The sequence always lands exactly on end, and there is no wrap-around past 2^WIDTH-1.
- Terminal tick, reload=1: counter_out=start, wrap pulses, remain in RUN.
- Terminal tick, reload=0: go to DONE, done pulses, counter_out holds end.
- DONE lasts one cycle, then IDLE. counter_out holds its last value in IDLE.
- start >= end: the first tick is terminal.
- HOLD: pause high in RUN at an edge moves to HOLD. No tick occurs that edge, and pre_cnt and counter_out are frozen. pause low in HOLD returns to RUN with pre_cnt preserved.
- abort: high in RUN/HOLD/DONE takes the block to IDLE next edge with aborted pulsed. counter_out is frozen and there is no done/wrap. Abort in IDLE is ignored.
- Priority: reset > abort > pause > tick.
- Reset mid-run: returns to IDLE and counter_out=0 the same edge, with no done or aborted pulse.
- All outputs are registered except cfg_ready and busy, which are decoded from the state register.

Decomposition:
- Shared header counter_ctrl_pkg holds:
  - state encodings (IDLE=0, RUN=1, HOLD=2, DONE=3)
  - WIDTH and PRE_W defaults
- Natural sub-module: tick_prescaler. Inputs clk, rst, enable, prescale; output tick. The FSM, clamp arithmetic and config registers stay in counter_sequencer.

Test Plan:
- One-shot: start=10, end=20, step=3, prescale=0, reload=0.
  - counter_out sequence 10,13,16,19,20 on consecutive edges.
  - Next edge: done=1 for one cycle.
  - Following edge: cfg_ready=1, counter_out stays 20.
- Prescale: start=0, end=4, step=1, prescale=2.
  - counter_out increments every 3 cycles: 0,1,2,3,4.
  - done 3 cycles after 4 appears; busy high throughout.
- Reload: start=250, end=255, step=2, reload=1, prescale=0.
  - counter_out 250,252,254,255,250,...
  - wrap pulses at each return to 250; no overflow to 0; done never asserts.
- Pause/abort:
  - pause high 5 cycles mid-run freezes counter_out and the prescale phase, and the run resumes with the same spacing.
  - abort then gives aborted=1 for one cycle, IDLE next edge, counter_out frozen, and no done.
- Edge cases:
  - step=0 behaves as step=1.
  - start=30, end=5 reaches done on the first tick with counter_out=30.
  - cfg_valid held while busy is not accepted.
- Reset: drive rst=0 mid-run.
  - Next edge: counter_out=0, busy=0, no pulses.
  - cfg_ready=0 until rst returns to 1.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
//   Shared definitions for the counter sequencer slice: sequencer state
//   encodings and default datapath widths.
package counter_ctrl_pkg;

  localparam int DEF_WIDTH = 8;  // counter / config value width
  localparam int DEF_PRE_W = 8;  // prescale field width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/counter_sequencer_tick_prescaler.sv
// tick_prescaler
//   Divides the clock into a tick that fires once every prescale+1 enabled
//   cycles. The phase counter freezes while enable is low and clears
//   while rst is low, so the owner can hold or restart the phase.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous clear, active-low
//   enable    in   advance the phase counter this cycle
//   prescale  in   tick period minus one
//   tick      out  high in the cycle where the phase counter reaches prescale
module tick_prescaler #(
  parameter int PRE_W = counter_ctrl_pkg::DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt;

  // Combinational so the sequencer can act on the tick in the same cycle.
  assign tick = enable && (pre_cnt == prescale);

  // NOTE: sequential state is only ever updated with non-blocking
  // assignments, so every flop samples pre-edge values regardless of
  // process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (enable) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Accepts a run configuration over a valid/ready handshake and drives
//   counter_out from start towards end in clamped steps, one step per
//   prescaled tick. Supports one-shot and auto-reload runs, pause and abort.
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   cfg_valid/ready configuration handshake (ready only in IDLE, out of reset)
//   cfg_start/end   first and terminal counter values
//   cfg_step        increment per tick (0 behaves as 1)
//   cfg_prescale    tick every prescale+1 cycles
//   cfg_reload      1 = restart at terminal, 0 = one-shot
//   pause, abort    freeze sequencing / terminate the run
//   counter_out     registered counter value
//   busy            state is not IDLE
//   done/wrap/aborted  registered one-cycle event pulses
module counter_sequencer
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_end,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic [PRE_W-1:0] cfg_prescale,
  input  logic             cfg_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] counter_out,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             aborted
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic             done_d, wrap_d, aborted_d;
  logic             load_cfg;

  logic [WIDTH-1:0] start_q, end_q, step_q;
  logic [PRE_W-1:0] prescale_q;
  logic             reload_q;

  logic             tick;
  logic             pre_run;
  logic [WIDTH-1:0] step_eff;
  logic [WIDTH:0]   sum;

  assign cfg_ready = (state_q == ST_IDLE) && rst;
  assign busy      = (state_q != ST_IDLE);

  // The phase counter is held cleared outside RUN/HOLD so every accepted
  // run starts its prescale phase at zero, while HOLD keeps the phase.
  assign pre_run = rst && ((state_q == ST_RUN) || (state_q == ST_HOLD));

  tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .rst      (pre_run),
    .enable   ((state_q == ST_RUN) && !pause && !abort),
    .prescale (prescale_q),
    .tick     (tick)
  );

  // One extra bit keeps the sum from wrapping past the top of the range
  // before it is clamped to end.
  assign step_eff = (step_q == '0) ? WIDTH'(1) : step_q;
  assign sum      = {1'b0, counter_out} + {1'b0, step_eff};

  // NOTE: every signal driven here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = counter_out;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    aborted_d = 1'b0;
    load_cfg  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          load_cfg = 1'b1;
          count_d  = cfg_start;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else if (tick) begin
          if (counter_out >= end_q) begin
            if (reload_q) begin
              count_d = start_q;
              wrap_d  = 1'b1;
            end else begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            count_d = (sum > {1'b0, end_q}) ? end_q : sum[WIDTH-1:0];
          end
        end
      end
      ST_HOLD: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        aborted_d = abort;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      counter_out <= '0;
      done        <= 1'b0;
      wrap        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_out <= count_d;
      done        <= done_d;
      wrap        <= wrap_d;
      aborted     <= aborted_d;
    end
  end

  // NOTE: the configuration registers are cleared by reset on purpose so a
  // reset always leaves the block in a fully known state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_q    <= '0;
      end_q      <= '0;
      step_q     <= '0;
      prescale_q <= '0;
      reload_q   <= 1'b0;
    end else if (load_cfg) begin
      start_q    <= cfg_start;
      end_q      <= cfg_end;
      step_q     <= cfg_step;
      prescale_q <= cfg_prescale;
      reload_q   <= cfg_reload;
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
//   Directed bench: a table of per-cycle vectors with hand-computed
//   expectations, then hand-written pause/abort and reset sequences.
//   Inputs change after the falling edge; outputs are checked at the next
//   falling edge, one rising edge later.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_start, cfg_end, cfg_step, cfg_prescale;
  logic       cfg_reload;
  logic       pause, abort;
  logic [7:0] counter_out;
  logic       busy, done, wrap, aborted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_start    (cfg_start),
    .cfg_end      (cfg_end),
    .cfg_step     (cfg_step),
    .cfg_prescale (cfg_prescale),
    .cfg_reload   (cfg_reload),
    .pause        (pause),
    .abort        (abort),
    .counter_out  (counter_out),
    .busy         (busy),
    .done         (done),
    .wrap         (wrap),
    .aborted      (aborted)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] s, e, st, p;
    logic       r, pause, abort;
    logic [7:0] cnt;
    logic       busy, done, wrap, ab, rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic rs, input logic v, input logic [7:0] s, input logic [7:0] e,
                     input logic [7:0] st, input logic [7:0] p, input logic r,
                     input logic pa, input logic ab_in, input logic [7:0] cnt,
                     input logic b, input logic d, input logic w, input logic a, input logic rdy);
    vec_t x;
    x.rst = rs; x.valid = v; x.s = s; x.e = e; x.st = st; x.p = p; x.r = r;
    x.pause = pa; x.abort = ab_in; x.cnt = cnt;
    x.busy = b; x.done = d; x.wrap = w; x.ab = a; x.rdy = rdy;
    vecs.push_back(x);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rs, input logic v, input logic [7:0] s, input logic [7:0] e,
                       input logic [7:0] st, input logic [7:0] p, input logic r,
                       input logic pa, input logic ab_in);
    rst = rs; cfg_valid = v; cfg_start = s; cfg_end = e; cfg_step = st;
    cfg_prescale = p; cfg_reload = r; pause = pa; abort = ab_in;
  endtask

  task automatic check_all(input string tag, input logic [7:0] cnt, input logic b,
                           input logic d, input logic w, input logic a, input logic rdy);
    check({tag, " counter_out"}, counter_out, cnt);
    check({tag, " busy"}, busy, b);
    check({tag, " done"}, done, d);
    check({tag, " wrap"}, wrap, w);
    check({tag, " aborted"}, aborted, a);
    check({tag, " cfg_ready"}, cfg_ready, rdy);
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    //   rst v  start   end   step  pre  rl pa ab   cnt  busy dn wr ab rdy
    // Reset, then one-shot 10..20 step 3; cfg_valid held while busy is ignored.
    add(0, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd0,   0, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd0,   0, 0, 0, 0, 1);
    add(1, 1, 8'd10,  8'd20,  8'd3, 8'd0, 0, 0, 0, 8'd10,  1, 0, 0, 0, 0);
    add(1, 1, 8'd99,  8'd200, 8'd7, 8'd5, 1, 0, 0, 8'd13,  1, 0, 0, 0, 0);
    add(1, 1, 8'd99,  8'd200, 8'd7, 8'd5, 1, 0, 0, 8'd16,  1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd19,  1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd20,  1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd20,  1, 1, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd20,  0, 0, 0, 0, 1);
    // start > end: first tick is terminal, counter holds start.
    add(1, 1, 8'd30,  8'd5,   8'd1, 8'd0, 0, 0, 0, 8'd30,  1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd30,  1, 1, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd30,  0, 0, 0, 0, 1);
    // step = 0 behaves as step = 1.
    add(1, 1, 8'd0,   8'd3,   8'd0, 8'd0, 0, 0, 0, 8'd0,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd1,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd2,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd3,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd3,   1, 1, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd3,   0, 0, 0, 0, 1);
    // Reload near the top of the range: clamps to 255, never overflows.
    add(1, 1, 8'd250, 8'd255, 8'd2, 8'd0, 1, 0, 0, 8'd250, 1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd252, 1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd254, 1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd255, 1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd250, 1, 0, 1, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd252, 1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd254, 1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd255, 1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd250, 1, 0, 1, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 1, 8'd250, 0, 0, 0, 1, 1);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd250, 0, 0, 0, 0, 1);
    // Prescale 2: one step every 3 cycles, done 3 cycles after reaching end.
    add(1, 1, 8'd0,   8'd4,   8'd1, 8'd2, 0, 0, 0, 8'd0,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd0,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd0,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd1,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd1,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd1,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd2,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd2,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd2,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd3,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd3,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd3,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd4,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd4,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd4,   1, 0, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd4,   1, 1, 0, 0, 0);
    add(1, 0, 8'd0,   8'd0,   8'd0, 8'd0, 0, 0, 0, 8'd4,   0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].s, vecs[i].e, vecs[i].st, vecs[i].p,
            vecs[i].r, vecs[i].pause, vecs[i].abort);
      cycle();
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].busy, vecs[i].done,
                vecs[i].wrap, vecs[i].ab, vecs[i].rdy);
    end

    // Pause for 5 edges with prescale 1: counter and prescale phase freeze,
    // and the tick lands on the first RUN edge after resuming.
    drive(1, 1, 8'd0, 8'd100, 8'd5, 8'd1, 0, 0, 0);
    cycle(); check_all("pz accept", 8'd0, 1, 0, 0, 0, 0);
    drive(1, 0, 8'd0, 8'd0, 8'd0, 8'd0, 0, 0, 0);
    cycle(); check_all("pz e1", 8'd0, 1, 0, 0, 0, 0);
    cycle(); check_all("pz e2", 8'd5, 1, 0, 0, 0, 0);
    cycle(); check_all("pz e3", 8'd5, 1, 0, 0, 0, 0);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(); check_all($sformatf("pz hold%0d", k), 8'd5, 1, 0, 0, 0, 0);
    end
    pause = 1'b0;
    cycle(); check_all("pz resume", 8'd5, 1, 0, 0, 0, 0);
    cycle(); check_all("pz tick", 8'd10, 1, 0, 0, 0, 0);
    cycle(); check_all("pz e11", 8'd10, 1, 0, 0, 0, 0);
    cycle(); check_all("pz e12", 8'd15, 1, 0, 0, 0, 0);
    // Abort beats pause.
    pause = 1'b1; abort = 1'b1;
    cycle(); check_all("ab run", 8'd15, 0, 0, 0, 1, 1);
    pause = 1'b0; abort = 1'b0;
    cycle(); check_all("ab after", 8'd15, 0, 0, 0, 0, 1);

    // Abort while in HOLD.
    drive(1, 1, 8'd7, 8'd100, 8'd1, 8'd0, 0, 0, 0);
    cycle(); check_all("abh accept", 8'd7, 1, 0, 0, 0, 0);
    drive(1, 0, 8'd0, 8'd0, 8'd0, 8'd0, 0, 1, 0);
    cycle(); check_all("abh hold", 8'd7, 1, 0, 0, 0, 0);
    abort = 1'b1;
    cycle(); check_all("abh abort", 8'd7, 0, 0, 0, 1, 1);

    // Abort in DONE pulses aborted; abort in IDLE is ignored.
    drive(1, 1, 8'd30, 8'd5, 8'd1, 8'd0, 0, 0, 0);
    cycle(); check_all("abd accept", 8'd30, 1, 0, 0, 0, 0);
    drive(1, 0, 8'd0, 8'd0, 8'd0, 8'd0, 0, 0, 0);
    cycle(); check_all("abd done", 8'd30, 1, 1, 0, 0, 0);
    abort = 1'b1;
    cycle(); check_all("abd abort", 8'd30, 0, 0, 0, 1, 1);
    cycle(); check_all("abd idle", 8'd30, 0, 0, 0, 0, 1);
    abort = 1'b0;

    // Reset mid-run: immediate return to IDLE with counter 0 and no pulses.
    drive(1, 1, 8'd0, 8'd100, 8'd1, 8'd0, 0, 0, 0);
    cycle(); check_all("rs accept", 8'd0, 1, 0, 0, 0, 0);
    drive(1, 0, 8'd0, 8'd0, 8'd0, 8'd0, 0, 0, 0);
    cycle(); check_all("rs e1", 8'd1, 1, 0, 0, 0, 0);
    cycle(); check_all("rs e2", 8'd2, 1, 0, 0, 0, 0);
    drive(0, 1, 8'd9, 8'd100, 8'd1, 8'd0, 0, 0, 0);
    cycle(); check_all("rs reset", 8'd0, 0, 0, 0, 0, 0);
    cycle(); check_all("rs held", 8'd0, 0, 0, 0, 0, 0);
    drive(1, 0, 8'd0, 8'd0, 8'd0, 8'd0, 0, 0, 0);
    #1 check("rs ready comb", cfg_ready, 1'b1);
    cycle(); check_all("rs release", 8'd0, 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
